// File: rtl/aes128_cipher.sv
// Iterative AES-128 encrypt/decrypt core.
// A key load expands the schedule once and caches K0 and K10. Each block
// then derives its round keys on the fly, forward from K0 for encryption
// and backward from K10 for decryption. The result is held until it is
// acknowledged.
// Handshake: start_i is taken on a rising edge only while ready_o=1 and
// key_load_i=0. done_o/data_o stay stable until an edge that sees
// result_ack_i=1. There is no queuing of start_i or key_load_i.
module aes128_cipher #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  output logic         done_o,
  input  logic         result_ack_i
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_cipher: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, KEXP, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic           key_valid_q;
  logic           mode_q;
  logic [3:0]     rnd_q;
  logic [127:0]   k0_q, k10_q, rk_q, st_q, data_q;
  logic [127:0]   kexp_next, run_st, run_rk;
  logic [3:0]     rnd_j;
  logic           run_last;

  // ---------------- GF(2^8) and S-box helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, which maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- key schedule steps ----------------
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undoes key_fwd: the last three words unwind by XOR, then the first
  // word needs the recovered last word of the previous key.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- round transforms ----------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r is row r of column c. Row r rotates left by r, or right when inv is set.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(inv ? (c+4-r)%4 : (c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      if (!inv)
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      else
        o[127-32*c -: 32] = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                             gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                             gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                             gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (!last) t = mix_columns(t, 1'b0);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (!last) t = mix_columns(t, 1'b1);
    return t;
  endfunction

  // ---------------- datapath combinational ----------------
  assign kexp_next = key_fwd(rk_q, rcon(rnd_q));
  assign run_last  = (rnd_q == 4'(11 - ROUNDS_PER_CYCLE));

  // Unrolled rounds for one RUN cycle, each deriving its own round key
  always_comb begin
    run_st = st_q;
    run_rk = rk_q;
    rnd_j  = rnd_q;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd_j = rnd_q + 4'(j);
      if (!mode_q) begin
        run_rk = key_fwd(run_rk, rcon(rnd_j));
        run_st = enc_round(run_st, run_rk, rnd_j == 4'd10);
      end else begin
        run_rk = key_inv(run_rk, rcon(4'd11 - rnd_j));
        run_st = dec_round(run_st, run_rk, rnd_j == 4'd10);
      end
    end
  end

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a key load wins over start, and start needs a valid key
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_load_i)                state_d = KEXP;
            else if (start_i && key_valid_q) state_d = RUN;
      KEXP: if (rnd_q == 4'd10)            state_d = IDLE;
      RUN:  if (run_last)                  state_d = DONE;
      DONE: if (result_ack_i)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    key_ready_o = (state_q == IDLE);
    ready_o     = (state_q == IDLE) && key_valid_q;
    done_o      = (state_q == DONE);
  end

  assign data_o = data_q;

  // Datapath registers: key cache, round state, round counter, result
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      rnd_q       <= 4'd0;
      k0_q        <= '0;
      k10_q       <= '0;
      rk_q        <= '0;
      st_q        <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_load_i) begin
            k0_q        <= key_i;
            rk_q        <= key_i;
            rnd_q       <= 4'd1;
            key_valid_q <= 1'b0;
          end else if (start_i && key_valid_q) begin
            mode_q <= decrypt_i;
            rnd_q  <= 4'd1;
            rk_q   <= decrypt_i ? k10_q : k0_q;
            st_q   <= data_i ^ (decrypt_i ? k10_q : k0_q);
          end
        end
        KEXP: begin
          rk_q  <= kexp_next;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd10) begin
            k10_q       <= kexp_next;
            key_valid_q <= 1'b1;
          end
        end
        RUN: begin
          st_q  <= run_st;
          rk_q  <= run_rk;
          rnd_q <= rnd_q + 4'(ROUNDS_PER_CYCLE);
          if (run_last) data_q <= run_st;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_cipher.sv
// Bench for aes128_cipher: four instances (1, 2, 5 and 10 rounds per cycle)
// share the same stimulus. Results are compared with known vectors and with
// a byte-matrix AES model.
module tb_aes128_cipher;

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] key;
  logic         start;
  logic         decrypt;
  logic [127:0] data_in;
  logic         ack;

  logic         key_ready_a [4];
  logic         ready_a     [4];
  logic         done_a      [4];
  logic [127:0] data_out_a  [4];

  int lat [4] = '{10, 5, 2, 1};

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_cipher #(
      .ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .key_load_i   (key_load),
      .key_i        (key),
      .key_ready_o  (key_ready_a[g]),
      .start_i      (start),
      .decrypt_i    (decrypt),
      .data_i       (data_in),
      .ready_o      (ready_a[g]),
      .data_o       (data_out_a[g]),
      .done_o       (done_a[g]),
      .result_ack_i (ack)
    );
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] m_rk [11];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from a brute-force inverse plus the bitwise affine map; the
  // inverse table is the S-box read backwards.
  task automatic build_tables();
    logic [7:0] inv, s, c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Cipher / inverse cipher on a 4x4 [row][col] byte matrix
  function automatic logic [127:0] model_aes(input logic dec, input logic [127:0] din);
    logic [7:0]   m  [4][4];
    logic [7:0]   t  [4][4];
    logic [7:0]   cf [4];
    logic [127:0] out;
    int           kidx;
    if (dec) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    kidx = dec ? 10 : 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = din[127-8*(4*c+r) -: 8] ^ m_rk[kidx][127-8*(4*c+r) -: 8];
    for (int n = 1; n <= 10; n++) begin
      kidx = dec ? 10 - n : n;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = dec ? isb[m[r][(c-r+4)%4]] : sb[m[r][(c+r)%4]];
      m = t;
      if (dec)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) m[r][c] = m[r][c] ^ m_rk[kidx][127-8*(4*c+r) -: 8];
      if (n < 10) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            t[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) t[r][c] = t[r][c] ^ gf_mul(cf[(k-r+4)%4], m[k][c]);
          end
        m = t;
      end
      if (!dec)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) m[r][c] = m[r][c] ^ m_rk[kidx][127-8*(4*c+r) -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) out[127-8*(4*c+r) -: 8] = m[r][c];
    return out;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int idx, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic kr, input logic rdy, input logic dn);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "/key_ready"}, i, 128'(key_ready_a[i]), 128'(kr));
      chk({tag, "/ready"},     i, 128'(ready_a[i]),     128'(rdy));
      chk({tag, "/done"},      i, 128'(done_a[i]),      128'(dn));
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Load a key (optionally with start in the same cycle) and follow KEXP
  task automatic load_key(input logic [127:0] k, input logic with_start, input string tag);
    key_load = 1'b1;
    key      = k;
    start    = with_start;
    decrypt  = 1'($urandom_range(0, 1));
    data_in  = rand128();
    tick();
    key_load = 1'b0;
    start    = 1'b0;
    key      = rand128();
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_all(tag, c == 10, c == 10, 1'b0);
    end
    model_expand(k);
  endtask

  // One block: exact latency per instance, optional hold with ignored
  // start/key_load pulses, then ack
  task automatic run_block(input logic dec, input logic [127:0] din, input logic [127:0] exp,
                           input int hold, input string tag);
    start   = 1'b1;
    decrypt = dec;
    data_in = din;
    tick();
    start   = 1'b0;
    decrypt = 1'($urandom_range(0, 1));
    data_in = rand128();
    for (int c = 1; c <= 10; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        chk({tag, "/done"}, i, 128'(done_a[i]), 128'(c >= lat[i]));
        if (c >= lat[i]) chk({tag, "/data"}, i, data_out_a[i], exp);
      end
    end
    for (int h = 0; h < hold; h++) begin
      if (h == hold / 2) begin
        start    = 1'b1;
        key_load = 1'b1;
        key      = rand128();
      end
      tick();
      start    = 1'b0;
      key_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk({tag, "/hold_done"}, i, 128'(done_a[i]), 128'(1'b1));
        chk({tag, "/hold_data"}, i, data_out_a[i], exp);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all({tag, "/ack"}, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk({tag, "/kept"}, i, data_out_a[i], exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] din, knew;
    logic         dec;

    build_tables();
    rst = 1'b1; key_load = 1'b0; key = '0; start = 1'b0;
    decrypt = 1'b0; data_in = '0; ack = 1'b0;
    tick();
    tick();
    chk_all("reset", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("reset/data", i, data_out_a[i], 128'h0);
    rst = 1'b0;
    tick();

    // start with no key loaded is ignored
    start = 1'b1; data_in = rand128();
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all("nokey", 1'b1, 1'b0, 1'b0);
    end

    // FIPS-197 key, cached K10, encrypt / decrypt
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, "kexp_fips");
    chk("k10", 0, g_dut[0].u_dut.k10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("k10", 3, g_dut[3].u_dut.k10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_block(1'b0, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 0, "enc_fips");
    run_block(1'b1, 128'h8df4e9aac5c7573a27d8d055d6e4d64b,
              128'h00112233445566778899aabbccddeeff, 0, "dec_vec");
    run_block(1'b1, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 0, "dec_rt");

    // result held for 20 cycles without ack
    din = rand128();
    run_block(1'b0, din, model_aes(1'b0, din), 20, "hold");

    // random interleaved encrypt/decrypt under one key
    for (int n = 0; n < 6; n++) begin
      dec = 1'($urandom_range(0, 1));
      din = rand128();
      run_block(dec, din, model_aes(dec, din), 0, "rand");
    end

    // Appendix C.1 vector across all unroll factors
    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0, "kexp_c1");
    run_block(1'b0, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "enc_c1");
    run_block(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 0, "dec_c1");

    // key load and start together: the load wins, no block runs
    knew = rand128();
    load_key(knew, 1'b1, "prio");
    for (int n = 0; n < 2; n++) begin
      dec = 1'($urandom_range(0, 1));
      din = rand128();
      run_block(dec, din, model_aes(dec, din), 0, "newkey");
    end

    // reset during round 5 of the slowest instance
    start = 1'b1; decrypt = 1'b0; data_in = rand128();
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("midreset", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("midreset/data", i, data_out_a[i], 128'h0);
    start = 1'b1; data_in = rand128();
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_all("postreset", 1'b1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
